// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide engine driving an external 3*WIDTH-bit state register.
// Optional macro MULTDIV_REMAINDER_EN adds the data_remainder output.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 clock,
    input  logic                 clr_n,
    input  logic [WIDTH-1:0]     data_operandA,
    input  logic [WIDTH-1:0]     data_operandB,
    input  logic                 ctrl_MULT,
    input  logic                 ctrl_DIV,
    input  logic [3*WIDTH-1:0]   state_q,
    output logic [3*WIDTH-1:0]   state_d,
    output logic                 state_we,
    output logic [WIDTH-1:0]     data_result,
    output logic                 data_exception,
    output logic                 data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0]     data_remainder
`endif
);

    localparam int CW = $clog2(ITER);
    localparam logic [2*WIDTH-1:0] LIMIT = (2*WIDTH)'(1) << (WIDTH-1);
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic           op_div;
    logic           neg_a;
    logic           neg_b;

    logic           start;
    logic           div_by_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh_hi;
    logic [WIDTH-1:0] sh_lo;
    logic             fits;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    logic             neg_res;
    logic [WIDTH-1:0] res_val;
    logic             res_exc;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_val;
`endif

    assign start       = ctrl_MULT | ctrl_DIV;
    assign abs_a       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign div_by_zero = ctrl_DIV && !ctrl_MULT && (data_operandB == '0);

    assign m  = state_q[3*WIDTH-1:2*WIDTH];
    assign hi = state_q[2*WIDTH-1:WIDTH];
    assign lo = state_q[WIDTH-1:0];

    // One shift-add (multiply) or restoring shift-subtract (divide) step on {HI,LO}.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        sh_hi   = {hi, lo[WIDTH-1]};
        sh_lo   = {lo[WIDTH-2:0], 1'b0};
        fits    = sh_hi >= {1'b0, m};
        next_hi = '0;
        next_lo = '0;
        if (op_div) begin
            next_hi = fits ? (sh_hi[WIDTH-1:0] - m) : sh_hi[WIDTH-1:0];
            next_lo = {sh_lo[WIDTH-1:1], fits};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        state_we = 1'b0;
        if (start) begin
            state_we = 1'b1;
            state_d  = {abs_b, {WIDTH{1'b0}}, abs_a};
        end else if (state == RUN) begin
            state_we = 1'b1;
            state_d  = {m, next_hi, next_lo};
        end
    end

    // Final result is formed from the last iteration's next value so it is registered on entry to DONE.
    always_comb begin
        neg_res = neg_a ^ neg_b;
        res_val = neg_res ? -next_lo : next_lo;
        if (op_div)
            res_exc = !neg_res && (next_lo == MIN_NEG);
        else if (neg_res)
            res_exc = {next_hi, next_lo} > LIMIT;
        else
            res_exc = {next_hi, next_lo} >= LIMIT;
`ifdef MULTDIV_REMAINDER_EN
        rem_val = neg_a ? -next_hi : next_hi;
`endif
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state          <= IDLE;
            count          <= '0;
            op_div         <= 1'b0;
            neg_a          <= 1'b0;
            neg_b          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                op_div         <= !ctrl_MULT;
                neg_a          <= data_operandA[WIDTH-1];
                neg_b          <= data_operandB[WIDTH-1];
                count          <= '0;
                data_result    <= '0;
                data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
                data_remainder <= '0;
`endif
                if (div_by_zero) begin
                    state          <= DONE;
                    data_resultRDY <= 1'b1;
                    data_exception <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        count <= count + 1'b1;
                        if (count == CW'(ITER-1)) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            data_result    <= res_val;
                            data_exception <= res_exc;
`ifdef MULTDIV_REMAINDER_EN
                            data_remainder <= op_div ? rem_val : '0;
`endif
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed plan cases plus randomized operations
// compared against an arithmetic reference model; models the external state register.
module tb_multdiv_seq;

    logic        clock;
    logic        clr_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [95:0] state_q;
    logic [95:0] state_d;
    logic        state_we;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int tests;
    int failed;

    multdiv_seq dut (
        .clock          (clock),
        .clr_n          (clr_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .state_q        (state_q),
        .state_d        (state_d),
        .state_we       (state_we),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef MULTDIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External enable register holding the engine's datapath state; never reset.
    initial state_q = '0;
    always @(posedge clock) if (state_we) state_q <= state_d;

    task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic do_div, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic exc,
                                      output logic [31:0] rem, output int lat,
                                      output logic [95:0] init);
        longint sa, sb, p, qs, rs;
        longint unsigned ua, ub, mag, q, r;
        logic neg;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        neg = (sa < 0) != (sb < 0);
        ua  = (sa < 0) ? longint'(-sa) : longint'(sa);
        ub  = (sb < 0) ? longint'(-sb) : longint'(sb);
        init = {ub[31:0], 32'h0, ua[31:0]};
        rem = '0;
        lat = 33;
        if (!do_div) begin
            mag = ua * ub;
            p   = neg ? -longint'(mag) : longint'(mag);
            res = p[31:0];
            exc = neg ? (mag > 64'h8000_0000) : (mag >= 64'h8000_0000);
        end else if (ub == 0) begin
            res = '0;
            exc = 1'b1;
            lat = 1;
        end else begin
            q   = ua / ub;
            r   = ua % ub;
            qs  = neg ? -longint'(q) : longint'(q);
            rs  = (sa < 0) ? -longint'(r) : longint'(r);
            res = qs[31:0];
            rem = rs[31:0];
            exc = !neg && (q == 64'h8000_0000);
        end
    endfunction

    // Drives one start pulse during cycle T and checks the register load; returns after T's edge.
    task automatic apply_stimulus(input string tag, input logic is_mult, input logic is_div,
                                  input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r_res, r_rem;
        logic        r_exc;
        int          r_lat;
        logic [95:0] r_init;
        ref_model(is_div && !is_mult, a, b, r_res, r_exc, r_rem, r_lat, r_init);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = is_mult;
        ctrl_DIV      = is_div;
        #1;
        check_output({tag, " start_we"}, 96'(state_we), 96'(1));
        check_output({tag, " start_d"}, state_d, r_init);
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Waits (bounded) for the ready pulse after the start edge and checks every result field.
    task automatic check_result(input string tag, input logic is_mult, input logic is_div,
                                input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r_res, r_rem, held;
        logic        r_exc;
        int          r_lat;
        logic [95:0] r_init;
        int          seen;
        ref_model(is_div && !is_mult, a, b, r_res, r_exc, r_rem, r_lat, r_init);
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                seen = n;
                break;
            end
        end
        check_output({tag, " latency"}, 96'(seen), 96'(r_lat));
        check_output({tag, " result"}, 96'(data_result), 96'(r_res));
        check_output({tag, " exception"}, 96'(data_exception), 96'(r_exc));
`ifdef MULTDIV_REMAINDER_EN
        check_output({tag, " remainder"}, 96'(data_remainder), 96'(r_rem));
`endif
        held = data_result;
        @(negedge clock);
        check_output({tag, " rdy_pulse"}, 96'(data_resultRDY), 96'(0));
        check_output({tag, " we_idle"}, 96'(state_we), 96'(0));
        check_output({tag, " hold"}, 96'(data_result), 96'(held));
    endtask

    task automatic run_op(input string tag, input logic is_mult, input logic is_div,
                          input logic [31:0] a, input logic [31:0] b);
        apply_stimulus(tag, is_mult, is_div, a, b);
        check_result(tag, is_mult, is_div, a, b);
    endtask

    initial begin
        int rdy_seen;
        logic [31:0] a, b;
        logic is_div;
        int tmp;

        tests         = 0;
        failed        = 0;
        clr_n         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check_output("reset result", 96'(data_result), 96'(0));
        check_output("reset exception", 96'(data_exception), 96'(0));
        check_output("reset rdy", 96'(data_resultRDY), 96'(0));
        check_output("reset we", 96'(state_we), 96'(0));
`ifdef MULTDIV_REMAINDER_EN
        check_output("reset remainder", 96'(data_remainder), 96'(0));
`endif
        @(negedge clock);
        clr_n = 1'b1;

        run_op("mul_7_m6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_minneg", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000);
        run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0);
        run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("both_ctrl", 1'b1, 1'b1, 32'd3, 32'd4);
        run_op("mul_zero", 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF);

        // Abort: a divide started ten cycles into a multiply must restart and give one ready pulse.
        apply_stimulus("abort_mul", 1'b1, 1'b0, 32'd100, 32'd5);
        rdy_seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check_output("abort early_rdy", 96'(rdy_seen), 96'(0));
        run_op("abort_div", 1'b0, 1'b1, 32'd9, 32'd3);

        // Asynchronous reset in the middle of a multiply.
        apply_stimulus("reset_mul", 1'b1, 1'b0, 32'd1234, 32'd567);
        repeat (14) @(posedge clock);
        #3;
        check_output("midrun we", 96'(state_we), 96'(1));
        clr_n = 1'b0;
        #1;
        check_output("async we", 96'(state_we), 96'(0));
        check_output("async rdy", 96'(data_resultRDY), 96'(0));
        check_output("async result", 96'(data_result), 96'(0));
        check_output("async exception", 96'(data_exception), 96'(0));
        repeat (2) @(negedge clock);
        clr_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check_output("post_reset no_rdy", 96'(rdy_seen), 96'(0));
        run_op("mul_2_3", 1'b1, 1'b0, 32'd2, 32'd3);

        for (int i = 0; i < 30; i++) begin
            a      = $urandom;
            b      = $urandom;
            is_div = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                1: begin
                    tmp = int'($urandom_range(0, 600)) - 300;
                    a   = tmp;
                    tmp = int'($urandom_range(0, 600)) - 300;
                    b   = tmp;
                end
                2: a = 32'h8000_0000;
                3: b = 32'd0;
                4: b = 32'hFFFF_FFFF;
                5: begin
                    tmp = int'($urandom_range(0, 131072)) - 65536;
                    a   = tmp;
                    tmp = int'($urandom_range(0, 131072)) - 65536;
                    b   = tmp;
                end
                default: ;
            endcase
            run_op(is_div ? "rand_div" : "rand_mul", !is_div, is_div, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
